// File: rtl/control_multicycle_if.sv
// Control bus between the multicycle controller and the MIPS datapath.
// Signal names match the instruction register fields and datapath enables.
interface control_multicycle_if;
    logic [5:0]  OPCODE;
    logic [15:0] OFFSET;
    logic        ZERO;
    logic        PC_control;
    logic [1:0]  PCsrc;
    logic        ReadWrite;
    logic        IRWrite;
    logic        MDRWrite;
    logic        RegWrite;
    logic        RegDst;
    logic        MemtoReg;
    logic        AWrite;
    logic        BWrite;
    logic        ULAout_ctrl;
    logic [2:0]  ULAop;
    logic        srcA_selector;
    logic [1:0]  srcB_selector;
    logic        illegal;
    logic        reset_out;

    // Controller side: reads instruction fields and flags, drives enables
    modport master (
        input  OPCODE, OFFSET, ZERO,
        output PC_control, PCsrc, ReadWrite, IRWrite, MDRWrite, RegWrite,
               RegDst, MemtoReg, AWrite, BWrite, ULAout_ctrl, ULAop,
               srcA_selector, srcB_selector, illegal, reset_out
    );

    // Datapath side
    modport slave (
        output OPCODE, OFFSET, ZERO,
        input  PC_control, PCsrc, ReadWrite, IRWrite, MDRWrite, RegWrite,
               RegDst, MemtoReg, AWrite, BWrite, ULAout_ctrl, ULAop,
               srcA_selector, srcB_selector, illegal, reset_out
    );
endinterface

// File: rtl/control_multicycle.sv
// Multicycle MIPS control FSM: fetch/decode, then R-type, addi, lw, sw, beq, j
// and the RESET opcode. Outputs are Moore-decoded from the state register so an
// asynchronous reset clears every enable immediately.
module control_multicycle #(
    parameter int MEM_WAIT   = 3,
    parameter int RESET_HOLD = 1
) (
    input logic                  clock,
    input logic                  reset,
    control_multicycle_if.master bus
);
    localparam int MAX_WAIT = (MEM_WAIT > RESET_HOLD) ? MEM_WAIT : RESET_HOLD;
    localparam int CW       = $clog2(MAX_WAIT + 1);

    localparam logic [CW-1:0] WAIT_LAST = CW'(MEM_WAIT - 1);
    localparam logic [CW-1:0] HOLD_LAST = CW'(RESET_HOLD - 1);
    localparam logic [CW-1:0] CNT_MAX   = {CW{1'b1}};

    localparam logic [5:0] OP_R     = 6'h00;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;
    localparam logic [5:0] OP_RESET = 6'h3F;

    localparam logic [5:0] F_ADD = 6'h20;
    localparam logic [5:0] F_SUB = 6'h22;
    localparam logic [5:0] F_AND = 6'h24;

    typedef enum logic [3:0] {
        S_RESET, S_FETCH, S_LATCH, S_DECODE, S_DISPATCH,
        S_R_EXEC, S_R_WB, S_I_EXEC, S_I_WB, S_ADDR,
        S_MEM_RD, S_MEM_WB, S_MEM_WR, S_BRANCH, S_JUMP, S_ILLEGAL
    } state_t;

    state_t        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [5:0]    funct;
    logic [9:0]    unused_offset_hi;

    assign funct            = bus.OFFSET[5:0];
    assign unused_offset_hi = bus.OFFSET[15:6];

    // State and wait counter; reset forces RESET with a cleared counter
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q <= S_RESET;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // Next-state selection; instruction fields are only looked at in dispatch/exec states
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_RESET:    if (cnt_q == HOLD_LAST) state_d = S_FETCH;
            S_FETCH:    if (cnt_q == WAIT_LAST) state_d = S_LATCH;
            S_LATCH:    state_d = S_DECODE;
            S_DECODE:   state_d = S_DISPATCH;
            S_DISPATCH: begin
                case (bus.OPCODE)
                    OP_R:     state_d = (funct == F_ADD || funct == F_SUB || funct == F_AND)
                                        ? S_R_EXEC : S_ILLEGAL;
                    OP_ADDI:  state_d = S_I_EXEC;
                    OP_LW,
                    OP_SW:    state_d = S_ADDR;
                    OP_BEQ:   state_d = S_BRANCH;
                    OP_J:     state_d = S_JUMP;
                    OP_RESET: state_d = S_RESET;
                    default:  state_d = S_ILLEGAL;
                endcase
            end
            S_R_EXEC:   state_d = S_R_WB;
            S_R_WB:     state_d = S_FETCH;
            S_I_EXEC:   state_d = S_I_WB;
            S_I_WB:     state_d = S_FETCH;
            S_ADDR:     state_d = (bus.OPCODE == OP_SW) ? S_MEM_WR : S_MEM_RD;
            S_MEM_RD:   if (cnt_q == WAIT_LAST) state_d = S_MEM_WB;
            S_MEM_WB:   state_d = S_FETCH;
            S_MEM_WR:   state_d = S_FETCH;
            S_BRANCH:   state_d = S_FETCH;
            S_JUMP:     state_d = S_FETCH;
            S_ILLEGAL:  state_d = S_ILLEGAL;
            default:    state_d = S_RESET;
        endcase
    end

    // Counter clears on every state change and saturates instead of wrapping
    always_comb begin
        cnt_d = cnt_q;
        if (state_d != state_q) begin
            cnt_d = '0;
        end else if (cnt_q != CNT_MAX) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    // Per-state datapath enables; anything not set in a state stays 0
    always_comb begin
        bus.PC_control    = 1'b0;
        bus.PCsrc         = 2'b00;
        bus.ReadWrite     = 1'b0;
        bus.IRWrite       = 1'b0;
        bus.MDRWrite      = 1'b0;
        bus.RegWrite      = 1'b0;
        bus.RegDst        = 1'b0;
        bus.MemtoReg      = 1'b0;
        bus.AWrite        = 1'b0;
        bus.BWrite        = 1'b0;
        bus.ULAout_ctrl   = 1'b0;
        bus.ULAop         = 3'b000;
        bus.srcA_selector = 1'b0;
        bus.srcB_selector = 2'b00;
        bus.illegal       = 1'b0;
        bus.reset_out     = 1'b0;
        case (state_q)
            S_RESET: bus.reset_out = 1'b1;
            S_FETCH: begin
                bus.srcB_selector = 2'b01;
                bus.ULAop         = 3'b001;
            end
            S_LATCH: begin
                bus.srcB_selector = 2'b01;
                bus.ULAop         = 3'b001;
                bus.PC_control    = 1'b1;
                bus.IRWrite       = 1'b1;
            end
            S_DECODE: begin
                // PC + (imm << 2) goes into ULAout as the branch target
                bus.AWrite        = 1'b1;
                bus.BWrite        = 1'b1;
                bus.srcB_selector = 2'b11;
                bus.ULAop         = 3'b001;
                bus.ULAout_ctrl   = 1'b1;
            end
            S_R_EXEC: begin
                bus.srcA_selector = 1'b1;
                bus.ULAout_ctrl   = 1'b1;
                case (funct)
                    F_SUB:   bus.ULAop = 3'b010;
                    F_AND:   bus.ULAop = 3'b011;
                    default: bus.ULAop = 3'b001;
                endcase
            end
            S_R_WB: begin
                bus.RegWrite = 1'b1;
                bus.RegDst   = 1'b1;
            end
            S_I_EXEC, S_ADDR: begin
                bus.srcA_selector = 1'b1;
                bus.srcB_selector = 2'b10;
                bus.ULAop         = 3'b001;
                bus.ULAout_ctrl   = 1'b1;
            end
            S_I_WB:   bus.RegWrite = 1'b1;
            S_MEM_RD: bus.MDRWrite = (cnt_q == WAIT_LAST);
            S_MEM_WB: begin
                bus.RegWrite = 1'b1;
                bus.MemtoReg = 1'b1;
            end
            S_MEM_WR: bus.ReadWrite = 1'b1;
            S_BRANCH: begin
                // PCsrc selects ULAout regardless; only the write enable follows ZERO
                bus.srcA_selector = 1'b1;
                bus.ULAop         = 3'b010;
                bus.PCsrc         = 2'b01;
                bus.PC_control    = bus.ZERO;
            end
            S_JUMP: begin
                bus.PCsrc      = 2'b10;
                bus.PC_control = 1'b1;
            end
            S_ILLEGAL: bus.illegal = 1'b1;
            default: ;
        endcase
    end
endmodule

// File: tb/tb_control_multicycle.sv
// Directed bench for control_multicycle: one task per scenario, each comparing the
// full output vector cycle by cycle against hand-written expected sequences.
module tb_control_multicycle;
    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [5:0]  opcode = 6'h00;
    logic [15:0] offset = 16'h0020;
    logic        zero = 1'b0;
    int          errors = 0;
    int          checks = 0;

    always #5 clk = ~clk;

    control_multicycle_if bus ();
    control_multicycle_if bus_h ();

    assign bus.OPCODE   = opcode;
    assign bus.OFFSET   = offset;
    assign bus.ZERO     = zero;
    assign bus_h.OPCODE = opcode;
    assign bus_h.OFFSET = offset;
    assign bus_h.ZERO   = zero;

    control_multicycle #(.MEM_WAIT(3), .RESET_HOLD(1)) dut (
        .clock(clk), .reset(reset), .bus(bus)
    );
    control_multicycle #(.MEM_WAIT(3), .RESET_HOLD(4)) dut_h (
        .clock(clk), .reset(reset), .bus(bus_h)
    );

    // {PC_control, PCsrc, ReadWrite, IRWrite, MDRWrite, RegWrite, RegDst, MemtoReg,
    //  AWrite, BWrite, ULAout_ctrl, ULAop, srcA, srcB, illegal, reset_out}
    logic [19:0] ov, ov_h;
    assign ov = {bus.PC_control, bus.PCsrc, bus.ReadWrite, bus.IRWrite, bus.MDRWrite,
                 bus.RegWrite, bus.RegDst, bus.MemtoReg, bus.AWrite, bus.BWrite,
                 bus.ULAout_ctrl, bus.ULAop, bus.srcA_selector, bus.srcB_selector,
                 bus.illegal, bus.reset_out};
    assign ov_h = {bus_h.PC_control, bus_h.PCsrc, bus_h.ReadWrite, bus_h.IRWrite, bus_h.MDRWrite,
                   bus_h.RegWrite, bus_h.RegDst, bus_h.MemtoReg, bus_h.AWrite, bus_h.BWrite,
                   bus_h.ULAout_ctrl, bus_h.ULAop, bus_h.srcA_selector, bus_h.srcB_selector,
                   bus_h.illegal, bus_h.reset_out};

    localparam logic [19:0] V_RST    = 20'h00001;
    localparam logic [19:0] V_FETCH  = 20'h00024;
    localparam logic [19:0] V_LATCH  = 20'h88024;
    localparam logic [19:0] V_DEC    = 20'h0072C;
    localparam logic [19:0] V_DISP   = 20'h00000;
    localparam logic [19:0] V_R_ADD  = 20'h00130;
    localparam logic [19:0] V_R_SUB  = 20'h00150;
    localparam logic [19:0] V_R_AND  = 20'h00170;
    localparam logic [19:0] V_R_WB   = 20'h03000;
    localparam logic [19:0] V_I_EXEC = 20'h00138;
    localparam logic [19:0] V_I_WB   = 20'h02000;
    localparam logic [19:0] V_MRD    = 20'h00000;
    localparam logic [19:0] V_MRD_L  = 20'h04000;
    localparam logic [19:0] V_MEM_WB = 20'h02800;
    localparam logic [19:0] V_MEM_WR = 20'h10000;
    localparam logic [19:0] V_BR_Z1  = 20'hA0050;
    localparam logic [19:0] V_BR_Z0  = 20'h20050;
    localparam logic [19:0] V_JUMP   = 20'hC0000;
    localparam logic [19:0] V_ILL    = 20'h00002;

    // Stimulus only: pulse reset for two cycles, release just after a rising edge
    task automatic pulse_reset(input logic [5:0] op, input logic [15:0] off, input logic z);
        @(posedge clk);
        #1;
        reset  = 1'b0;
        opcode = op;
        offset = off;
        zero   = z;
        repeat (2) @(posedge clk);
        #1 reset = 1'b1;
    endtask

    task automatic test_reset();
        logic [19:0] exp_q[$];
        #2 reset = 1'b0;
        repeat (3) begin
            @(negedge clk);
            checks++;
            if (ov !== V_RST || ov_h !== V_RST) begin
                errors++;
                $display("FAIL reset_hold got=%05h/%05h exp=%05h", ov, ov_h, V_RST);
            end
        end
        @(posedge clk);
        #1 reset = 1'b1;
        exp_q = '{V_RST, V_FETCH, V_FETCH, V_FETCH, V_LATCH};
        foreach (exp_q[i]) begin
            @(negedge clk);
            checks++;
            if (ov !== exp_q[i]) begin
                errors++;
                $display("FAIL reset_release cyc%0d got=%05h exp=%05h", i, ov, exp_q[i]);
            end
        end
    endtask

    task automatic test_rtype(input string name, input logic [15:0] off, input logic [19:0] v_exec);
        logic [19:0] exp_q[$];
        pulse_reset(6'h00, off, 1'b0);
        exp_q = '{V_RST, V_FETCH, V_FETCH, V_FETCH, V_LATCH, V_DEC, V_DISP,
                  v_exec, V_R_WB, V_FETCH};
        foreach (exp_q[i]) begin
            @(negedge clk);
            checks++;
            if (ov !== exp_q[i]) begin
                errors++;
                $display("FAIL %s cyc%0d got=%05h exp=%05h", name, i, ov, exp_q[i]);
            end
        end
    endtask

    task automatic test_back_to_back();
        logic [19:0] exp_q[$];
        pulse_reset(6'h08, 16'h0005, 1'b0);
        exp_q = '{V_RST, V_FETCH, V_FETCH, V_FETCH, V_LATCH, V_DEC, V_DISP, V_I_EXEC, V_I_WB,
                  V_FETCH, V_FETCH, V_FETCH, V_LATCH, V_DEC, V_DISP, V_I_EXEC, V_I_WB, V_FETCH};
        foreach (exp_q[i]) begin
            @(negedge clk);
            checks++;
            if (ov !== exp_q[i]) begin
                errors++;
                $display("FAIL addi_b2b cyc%0d got=%05h exp=%05h", i, ov, exp_q[i]);
            end
        end
    endtask

    task automatic test_load_store();
        logic [19:0] exp_q[$];
        pulse_reset(6'h23, 16'h0010, 1'b0);
        exp_q = '{V_RST, V_FETCH, V_FETCH, V_FETCH, V_LATCH, V_DEC, V_DISP, V_I_EXEC,
                  V_MRD, V_MRD, V_MRD_L, V_MEM_WB, V_FETCH};
        foreach (exp_q[i]) begin
            @(negedge clk);
            checks++;
            if (ov !== exp_q[i]) begin
                errors++;
                $display("FAIL lw cyc%0d got=%05h exp=%05h", i, ov, exp_q[i]);
            end
        end
        pulse_reset(6'h2B, 16'h0010, 1'b0);
        exp_q = '{V_RST, V_FETCH, V_FETCH, V_FETCH, V_LATCH, V_DEC, V_DISP, V_I_EXEC,
                  V_MEM_WR, V_FETCH};
        foreach (exp_q[i]) begin
            @(negedge clk);
            checks++;
            if (ov !== exp_q[i]) begin
                errors++;
                $display("FAIL sw cyc%0d got=%05h exp=%05h", i, ov, exp_q[i]);
            end
        end
    endtask

    task automatic test_branch_jump();
        logic [19:0] exp_q[$];
        pulse_reset(6'h04, 16'h0003, 1'b1);
        exp_q = '{V_RST, V_FETCH, V_FETCH, V_FETCH, V_LATCH, V_DEC, V_DISP, V_BR_Z1, V_FETCH};
        foreach (exp_q[i]) begin
            @(negedge clk);
            checks++;
            if (ov !== exp_q[i]) begin
                errors++;
                $display("FAIL beq_taken cyc%0d got=%05h exp=%05h", i, ov, exp_q[i]);
            end
        end
        pulse_reset(6'h04, 16'h0003, 1'b0);
        exp_q = '{V_RST, V_FETCH, V_FETCH, V_FETCH, V_LATCH, V_DEC, V_DISP, V_BR_Z0, V_FETCH};
        foreach (exp_q[i]) begin
            @(negedge clk);
            checks++;
            if (ov !== exp_q[i]) begin
                errors++;
                $display("FAIL beq_not_taken cyc%0d got=%05h exp=%05h", i, ov, exp_q[i]);
            end
        end
        pulse_reset(6'h02, 16'h0100, 1'b0);
        exp_q = '{V_RST, V_FETCH, V_FETCH, V_FETCH, V_LATCH, V_DEC, V_DISP, V_JUMP, V_FETCH};
        foreach (exp_q[i]) begin
            @(negedge clk);
            checks++;
            if (ov !== exp_q[i]) begin
                errors++;
                $display("FAIL jump cyc%0d got=%05h exp=%05h", i, ov, exp_q[i]);
            end
        end
    endtask

    task automatic test_reset_op_illegal();
        logic [19:0] exp_q[$];
        // RESET opcode on the RESET_HOLD=4 instance
        pulse_reset(6'h3F, 16'h0000, 1'b0);
        exp_q = '{V_RST, V_RST, V_RST, V_RST, V_FETCH, V_FETCH, V_FETCH, V_LATCH, V_DEC, V_DISP,
                  V_RST, V_RST, V_RST, V_RST, V_FETCH};
        foreach (exp_q[i]) begin
            @(negedge clk);
            checks++;
            if (ov_h !== exp_q[i]) begin
                errors++;
                $display("FAIL reset_opcode cyc%0d got=%05h exp=%05h", i, ov_h, exp_q[i]);
            end
        end
        // Unknown opcode: flag stays set even after a legal opcode appears
        pulse_reset(6'h3E, 16'h0000, 1'b0);
        exp_q = '{V_RST, V_RST, V_RST, V_RST, V_FETCH, V_FETCH, V_FETCH, V_LATCH, V_DEC, V_DISP,
                  V_ILL, V_ILL, V_ILL};
        foreach (exp_q[i]) begin
            @(negedge clk);
            checks++;
            if (ov_h !== exp_q[i]) begin
                errors++;
                $display("FAIL illegal_op cyc%0d got=%05h exp=%05h", i, ov_h, exp_q[i]);
            end
        end
        opcode = 6'h00;
        offset = 16'h0020;
        repeat (3) begin
            @(negedge clk);
            checks++;
            if (ov_h !== V_ILL) begin
                errors++;
                $display("FAIL illegal_sticky got=%05h exp=%05h", ov_h, V_ILL);
            end
        end
        // Unknown R-type funct on the default instance
        pulse_reset(6'h00, 16'h0021, 1'b0);
        exp_q = '{V_RST, V_FETCH, V_FETCH, V_FETCH, V_LATCH, V_DEC, V_DISP, V_ILL, V_ILL};
        foreach (exp_q[i]) begin
            @(negedge clk);
            checks++;
            if (ov !== exp_q[i]) begin
                errors++;
                $display("FAIL illegal_funct cyc%0d got=%05h exp=%05h", i, ov, exp_q[i]);
            end
        end
    endtask

    task automatic test_async_reset_mem_wb();
        logic [19:0] exp_q[$];
        pulse_reset(6'h23, 16'h0008, 1'b0);
        exp_q = '{V_RST, V_FETCH, V_FETCH, V_FETCH, V_LATCH, V_DEC, V_DISP, V_I_EXEC,
                  V_MRD, V_MRD, V_MRD_L, V_MEM_WB};
        foreach (exp_q[i]) begin
            @(negedge clk);
            checks++;
            if (ov !== exp_q[i]) begin
                errors++;
                $display("FAIL lw_pre_abort cyc%0d got=%05h exp=%05h", i, ov, exp_q[i]);
            end
        end
        // Mid-cycle, well before the next rising edge
        #2 reset = 1'b0;
        #1;
        checks++;
        if (ov !== V_RST) begin
            errors++;
            $display("FAIL async_abort got=%05h exp=%05h", ov, V_RST);
        end
        @(negedge clk);
        checks++;
        if (ov !== V_RST) begin
            errors++;
            $display("FAIL async_abort_hold got=%05h exp=%05h", ov, V_RST);
        end
        @(posedge clk);
        #1 reset = 1'b1;
        exp_q = '{V_RST, V_FETCH};
        foreach (exp_q[i]) begin
            @(negedge clk);
            checks++;
            if (ov !== exp_q[i]) begin
                errors++;
                $display("FAIL post_abort cyc%0d got=%05h exp=%05h", i, ov, exp_q[i]);
            end
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog timeout");
        $fatal(1, "timeout");
    end

    initial begin
        test_reset();
        test_rtype("add", 16'h1820, V_R_ADD);
        test_rtype("sub", 16'h1822, V_R_SUB);
        test_rtype("and", 16'h1824, V_R_AND);
        test_back_to_back();
        test_load_store();
        test_branch_jump();
        test_reset_op_illegal();
        test_async_reset_mem_wb();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
